// File: rtl/uart_tx.sv
// uart_tx: transmit serializer between the downstream FIFO and the serial pin.
// It pops bytes from a show-ahead FIFO and frames each one as start, data
// (LSB first), optional parity, and one or two stop bits.
//
// Ports:
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_en                transmitter enable (gates new loads only)
//   i_baud_div          clocks per bit minus 1
//   i_data_bits         0:5 1:6 2:7 3:8 data bits
//   i_parity_en/odd     parity enable / odd select
//   i_stop2             two stop bits when set
//   i_fifo_empty/data   FIFO status and head word
//   o_fifo_read_req     one-cycle pop, asserted in the cycle the head is captured
//   o_tx                serial line, idle high, registered
//   o_busy              frame in progress
//   o_done              one-cycle pulse after the last stop clock
module uart_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BAUD_DIV_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [BAUD_DIV_W-1:0] i_baud_div,
  input  logic [1:0]            i_data_bits,
  input  logic                  i_parity_en,
  input  logic                  i_parity_odd,
  input  logic                  i_stop2,
  input  logic                  i_fifo_empty,
  input  logic [DATA_W-1:0]     i_fifo_data,
  output logic                  o_fifo_read_req,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [BAUD_DIV_W-1:0] cnt_q, cnt_d;
  logic [BAUD_DIV_W-1:0] div_q, div_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [1:0]            nbits_q, nbits_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  logic            bit_end;
  logic            frame_end;
  logic            load;
  logic            par_new;
  logic [IdxW-1:0] last_idx;

  assign bit_end   = (cnt_q == '0);
  assign frame_end = (state_q == StStop) && bit_end && (stop_idx_q == stop2_q);
  assign load      = i_en & ~i_fifo_empty & ~i_rst & ((state_q == StIdle) | frame_end);
  assign last_idx  = IdxW'(4 + int'(nbits_q));

  // Parity over the active data bits only; computed once at load time.
  always_comb begin
    par_new = i_parity_odd;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i < 5 + int'(i_data_bits)) begin
        par_new = par_new ^ i_fifo_data[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? cnt_q : cnt_q - 1'b1;
    div_d      = div_q;
    data_d     = data_q;
    idx_d      = idx_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
          tx_d    = data_q[0];
          cnt_d   = div_q;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = div_q;
          if (idx_q == last_idx) begin
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_bit_q;
            end else begin
              state_d    = StStop;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            // Shift so the next bit to send always sits at data_q[0].
            idx_d  = idx_q + 1'b1;
            data_d = data_q >> 1;
            tx_d   = data_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
          cnt_d      = div_q;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_idx_q != stop2_q) begin
            stop_idx_d = 1'b1;
            cnt_d      = div_q;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // A load overrides the frame-end return to idle, giving back-to-back frames.
    if (load) begin
      state_d    = StStart;
      tx_d       = 1'b0;
      data_d     = i_fifo_data;
      nbits_d    = i_data_bits;
      par_en_d   = i_parity_en;
      par_bit_d  = par_new;
      stop2_d    = i_stop2;
      div_d      = i_baud_div;
      cnt_d      = i_baud_div;
      idx_d      = '0;
      stop_idx_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_q      <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign o_fifo_read_req = load;
  assign o_tx            = tx_q;
  assign o_busy          = (state_q != StIdle);
  assign o_done          = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. A behavioural FIFO feeds the DUT;
// whenever the model predicts a pop, the expected per-clock line trace of that
// frame is pushed to a scoreboard queue and popped/compared every cycle.
module tb_uart_tx;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic        par_en;
  logic        par_odd;
  logic        stop2;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        read_req;
  logic        tx;
  logic        busy;
  logic        done;

  uart_tx #(
    .DATA_W    (8),
    .BAUD_DIV_W(16)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_en           (en),
    .i_baud_div     (baud_div),
    .i_data_bits    (data_bits),
    .i_parity_en    (par_en),
    .i_parity_odd   (par_odd),
    .i_stop2        (stop2),
    .i_fifo_empty   (fifo_empty),
    .i_fifo_data    (fifo_data),
    .o_fifo_read_req(read_req),
    .o_tx           (tx),
    .o_busy         (busy),
    .o_done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic tx;
    logic last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  logic       tx_log[$];
  int         done_cycs[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic cur_busy = 1'b0;
  logic cur_last = 1'b0;
  logic mon_en = 1'b0;
  logic prev_busy = 1'b0;
  int   n_pops, n_dones, busy_cyc, first_busy, busy_falls;

  function automatic void push_frame(input logic [7:0] d);
    logic bits[$];
    int   n;
    int   reps;
    logic p;
    n    = 5 + int'(data_bits);
    reps = int'(baud_div) + 1;
    p    = par_odd;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (par_en) bits.push_back(p);
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++) begin
      for (int r = 0; r < reps; r++) begin
        exp_q.push_back('{tx: bits[k], last: (k == bits.size() - 1) && (r == reps - 1)});
      end
    end
  endfunction

  task automatic update_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push_word(input logic [7:0] d);
    fifo_q.push_back(d);
    update_fifo();
  endtask

  task automatic clear_stats();
    n_pops     = 0;
    n_dones    = 0;
    busy_cyc   = 0;
    first_busy = -1;
    busy_falls = 0;
    tx_log.delete();
    done_cycs.delete();
  endtask

  // One clock: check the pop request, advance, then check line/busy/done.
  task automatic tick();
    logic exp_rr;
    logic prev_last;
    logic exp_tx;
    exp_t e;
    #1;
    exp_rr = en && !rst && (fifo_q.size() > 0) && (!cur_busy || cur_last);
    if (mon_en) begin
      n_cmp++;
      if (read_req !== exp_rr) begin
        n_err++;
        $display("FAIL read_req cyc=%0d actual=%b required=%b", cyc, read_req, exp_rr);
      end
    end
    if (read_req === 1'b1) n_pops++;
    @(posedge clk);
    #1;
    cyc++;
    prev_last = cur_last;
    if (rst) begin
      exp_q.delete();
      prev_last = 1'b0;
    end else if (exp_rr) begin
      push_frame(fifo_q.pop_front());
    end
    if (exp_q.size() > 0) begin
      e        = exp_q.pop_front();
      cur_busy = 1'b1;
      cur_last = e.last;
      exp_tx   = e.tx;
    end else begin
      cur_busy = 1'b0;
      cur_last = 1'b0;
      exp_tx   = 1'b1;
    end
    if (mon_en) begin
      n_cmp++;
      if (busy !== cur_busy) begin
        n_err++;
        $display("FAIL busy cyc=%0d actual=%b required=%b", cyc, busy, cur_busy);
      end
      n_cmp++;
      if (tx !== exp_tx) begin
        n_err++;
        $display("FAIL tx cyc=%0d actual=%b required=%b", cyc, tx, exp_tx);
      end
      n_cmp++;
      if (done !== prev_last) begin
        n_err++;
        $display("FAIL done cyc=%0d actual=%b required=%b", cyc, done, prev_last);
      end
    end
    if (busy === 1'b1) begin
      busy_cyc++;
      if (first_busy < 0) first_busy = cyc;
      tx_log.push_back(tx);
    end
    if (prev_busy && busy !== 1'b1) busy_falls++;
    prev_busy = (busy === 1'b1);
    if (done === 1'b1) begin
      n_dones++;
      done_cycs.push_back(cyc);
    end
    update_fifo();
  endtask

  task automatic run_idle(input int max_cyc);
    int k;
    k = 0;
    while ((cur_busy || (en && fifo_q.size() > 0)) && k < max_cyc) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k >= max_cyc) begin
      n_err++;
      $display("FAIL idle_timeout actual=%0d cycles required<%0d", k, max_cyc);
    end
  endtask

  task automatic set_cfg(input int div, input int bits, input logic pe, input logic po,
                         input logic s2);
    baud_div  = 16'(div);
    data_bits = 2'(bits);
    par_en    = pe;
    par_odd   = po;
    stop2     = s2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    set_cfg(3, 3, 1'b0, 1'b0, 1'b0);
    push_word(8'hEE);
    tick();
    tick();
    mon_en = 1'b1;
    clear_stats();
    tick();
    tick();
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL reset_tx actual=%b required=1", tx);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy_done actual=%b%b required=00", busy, done);
    end
    n_cmp++;
    if (n_pops !== 0) begin
      n_err++;
      $display("FAIL reset_no_pop actual=%0d required=0", n_pops);
    end
    fifo_q.delete();
    update_fifo();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_8n1();
    int gap;
    set_cfg(3, 3, 1'b0, 1'b0, 1'b0);
    clear_stats();
    push_word(8'hA5);
    run_idle(200);
    n_cmp++;
    if (n_pops !== 1) begin
      n_err++;
      $display("FAIL 8n1_pops actual=%0d required=1", n_pops);
    end
    n_cmp++;
    if (busy_cyc !== 40) begin
      n_err++;
      $display("FAIL 8n1_busy_len actual=%0d required=40", busy_cyc);
    end
    gap = (done_cycs.size() > 0) ? done_cycs[0] - first_busy : -1;
    n_cmp++;
    if (gap !== 40 || n_dones !== 1) begin
      n_err++;
      $display("FAIL 8n1_done actual=gap %0d count %0d required=gap 40 count 1", gap, n_dones);
    end
  endtask

  task automatic test_7e2();
    set_cfg(0, 2, 1'b1, 1'b0, 1'b1);
    clear_stats();
    push_word(8'hC1);  // bit 7 set but must be ignored
    run_idle(100);
    n_cmp++;
    if (busy_cyc !== 11 || n_dones !== 1) begin
      n_err++;
      $display("FAIL 7e2_len actual=%0d/%0d required=11/1", busy_cyc, n_dones);
    end
    n_cmp++;
    if (tx_log.size() != 11 || tx_log[8] !== 1'b0) begin
      n_err++;
      $display("FAIL 7e2_parity actual=%b required=0",
               (tx_log.size() > 8) ? tx_log[8] : 1'bx);
    end
  endtask

  task automatic test_8o1();
    set_cfg(1, 3, 1'b1, 1'b1, 1'b0);
    clear_stats();
    push_word(8'h00);
    push_word(8'h01);
    run_idle(200);
    n_cmp++;
    if (busy_cyc !== 44 || n_dones !== 2) begin
      n_err++;
      $display("FAIL 8o1_len actual=%0d/%0d required=44/2", busy_cyc, n_dones);
    end
    n_cmp++;
    if (tx_log.size() != 44 || tx_log[18] !== 1'b1 || tx_log[40] !== 1'b0) begin
      n_err++;
      $display("FAIL 8o1_parity actual=%b%b required=10",
               (tx_log.size() > 18) ? tx_log[18] : 1'bx,
               (tx_log.size() > 40) ? tx_log[40] : 1'bx);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    set_cfg(2, 3, 1'b0, 1'b0, 1'b0);
    clear_stats();
    push_word(8'h3C);
    push_word(8'hC3);
    run_idle(200);
    n_cmp++;
    if (n_pops !== 2 || busy_cyc !== 60) begin
      n_err++;
      $display("FAIL b2b_pops_busy actual=%0d/%0d required=2/60", n_pops, busy_cyc);
    end
    gap = (done_cycs.size() > 1) ? done_cycs[1] - done_cycs[0] : -1;
    n_cmp++;
    if (gap !== 30) begin
      n_err++;
      $display("FAIL b2b_done_gap actual=%0d required=30", gap);
    end
    n_cmp++;
    if (busy_falls !== 1) begin
      n_err++;
      $display("FAIL b2b_busy_gap actual=%0d falls required=1", busy_falls);
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    set_cfg(1, 3, 1'b0, 1'b0, 1'b0);
    clear_stats();
    push_word(8'h5A);
    push_word(8'h99);
    k = 0;
    while (busy_cyc < 9 && k < 50) begin
      tick();
      k++;
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid actual=tx %b busy %b required=tx 1 busy 0", tx, busy);
    end
    n_cmp++;
    if (n_pops !== 1 || fifo_q.size() != 1) begin
      n_err++;
      $display("FAIL rst_mid_pop actual=%0d required=1", n_pops);
    end
    rst = 1'b0;
    run_idle(100);
    n_cmp++;
    if (n_pops !== 2 || n_dones !== 1 || busy_cyc !== 29) begin
      n_err++;
      $display("FAIL rst_mid_recover actual=%0d/%0d/%0d required=2/1/29",
               n_pops, n_dones, busy_cyc);
    end
  endtask

  task automatic test_enable();
    set_cfg(0, 3, 1'b0, 1'b0, 1'b0);
    clear_stats();
    en = 1'b0;
    push_word(8'h77);
    for (int i = 0; i < 12; i++) tick();
    n_cmp++;
    if (n_pops !== 0 || busy_cyc !== 0) begin
      n_err++;
      $display("FAIL en_off actual=%0d/%0d required=0/0", n_pops, busy_cyc);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    push_word(8'h11);
    en = 1'b0;
    run_idle(100);
    n_cmp++;
    if (n_pops !== 1 || n_dones !== 1 || fifo_q.size() != 1) begin
      n_err++;
      $display("FAIL en_drop actual=%0d/%0d/%0d required=1/1/1",
               n_pops, n_dones, fifo_q.size());
    end
    fifo_q.delete();
    update_fifo();
    en = 1'b1;
    tick();
  endtask

  task automatic test_config_hold();
    set_cfg(0, 3, 1'b0, 1'b0, 1'b0);
    clear_stats();
    push_word(8'hB4);
    tick();
    tick();
    set_cfg(5, 0, 1'b1, 1'b1, 1'b1);
    run_idle(100);
    n_cmp++;
    if (busy_cyc !== 10 || n_dones !== 1) begin
      n_err++;
      $display("FAIL cfg_hold actual=%0d/%0d required=10/1", busy_cyc, n_dones);
    end
  endtask

  initial begin
    fifo_q.delete();
    update_fifo();
    test_reset();
    test_8n1();
    test_7e2();
    test_8o1();
    test_back_to_back();
    test_reset_mid_frame();
    test_enable();
    test_config_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
